// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Status codes, nibble split layout and FSM states.
package adder_arb_pkg;

  localparam int SUM_W = 8;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_MAX   = 2'b01,
    ST_OTHER = 2'b10
  } status_e;

  // y is declared first so that x lands in bits [3:0].
  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  function automatic status_e decode_status(input logic [SUM_W-1:0] sum);
    status_e st;
    if (sum == '0) begin
      st = ST_ZERO;
    end else if (sum == '1) begin
      st = ST_MAX;
    end else begin
      st = ST_OTHER;
    end
    return st;
  endfunction

endpackage

// File: rtl/adder_status_unit.sv
// Registered 8-bit add with carry, status decode and nibble split.
// Results only update while i_en is high, so they hold stable afterwards.
module adder_status_unit
  import adder_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [SUM_W-1:0] i_a,
  input  logic [SUM_W-1:0] i_b,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_carry,
  output logic [1:0]       o_status,
  output nibble_t          o_nib
);

  logic [SUM_W:0]   w_full;
  logic [SUM_W-1:0] r_sum;
  logic             r_carry;
  status_e          r_status;
  nibble_t          r_nib;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_status <= ST_ZERO;
      r_nib    <= '0;
    end else if (i_en) begin
      r_sum    <= w_full[SUM_W-1:0];
      r_carry  <= w_full[SUM_W];
      r_status <= decode_status(w_full[SUM_W-1:0]);
      r_nib.x  <= w_full[3:0];
      r_nib.y  <= w_full[7:4];
    end
  end

  assign o_sum    = r_sum;
  assign o_carry  = r_carry;
  assign o_status = r_status;
  assign o_nib    = r_nib;

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder/status unit between
// N_REQ requesters, with valid/ready on both request and response sides.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid [N_REQ],
  output logic             req_ready [N_REQ],
  input  logic [SUM_W-1:0] req_a     [N_REQ],
  input  logic [SUM_W-1:0] req_b     [N_REQ],
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [SUM_W-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic [1:0]       rsp_status,
  output nibble_t          rsp_nib,
  output logic             busy,
  output logic [CNT_W-1:0] served_cnt
);

  state_e           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [SUM_W-1:0] r_a;
  logic [SUM_W-1:0] r_b;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any_valid;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_take;
  logic [ID_W-1:0]  w_next_ptr;

  // Scan offsets from the highest down so the nearest valid index at or
  // after r_rr_ptr is the last one written.
  always_comb begin
    w_any_valid = 1'b0;
    w_grant_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_any_valid = 1'b1;
        w_grant_id  = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  // A grant can only happen from IDLE, or from RESP on the handshake cycle.
  assign w_take = rst_n && w_any_valid &&
                  ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));

  assign w_next_ptr = (int'(w_grant_id) == N_REQ - 1) ? '0 : w_grant_id + 1'b1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_take && (w_grant_id == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_take) begin
        r_a      <= req_a[w_grant_id];
        r_b      <= req_b[w_grant_id];
        r_id     <= w_grant_id;
        r_rr_ptr <= w_next_ptr;
      end
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_take) begin
              r_state <= CALC;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  adder_status_unit u_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state == CALC),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_sum    (rsp_sum),
    .o_carry  (rsp_carry),
    .o_status (rsp_status),
    .o_nib    (rsp_nib)
  );

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign busy       = r_busy;
  assign served_cnt = r_cnt;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: single-op vector table plus
// back-to-back round robin, response stall and mid-op reset sequences.
module tb_adder_rr_arbiter;
  import adder_arb_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid [N];
  logic       req_ready [N];
  logic [7:0] req_a [N];
  logic [7:0] req_b [N];
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [7:0] rsp_sum;
  logic       rsp_carry;
  logic [1:0] rsp_status;
  nibble_t    rsp_nib;
  logic       busy;
  logic [15:0] served_cnt;

  adder_rr_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .rsp_status (rsp_status),
    .rsp_nib    (rsp_nib),
    .busy       (busy),
    .served_cnt (served_cnt)
  );

  always #5 clk = ~clk;

  logic [3:0] rdy_vec;
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < N; i++) rdy_vec[i] = req_ready[i];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_valid(input logic v);
    for (int i = 0; i < N; i++) req_valid[i] = v;
  endtask

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    logic [1:0] status;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] rr_a   [N];
  logic [7:0] rr_b   [N];
  logic [7:0] rr_sum [N];
  logic       rr_c   [N];

  initial begin
    int exp_cnt;

    vecs[0] = '{id: 2'd2, a: 8'h12, b: 8'h34, sum: 8'h46, carry: 1'b0, status: 2'b10};
    vecs[1] = '{id: 2'd0, a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1, status: 2'b00};
    vecs[2] = '{id: 2'd1, a: 8'h80, b: 8'h7F, sum: 8'hFF, carry: 1'b0, status: 2'b01};
    vecs[3] = '{id: 2'd3, a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0, status: 2'b00};
    vecs[4] = '{id: 2'd1, a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1, status: 2'b10};
    vecs[5] = '{id: 2'd0, a: 8'hA5, b: 8'h5A, sum: 8'hFF, carry: 1'b0, status: 2'b01};

    rr_a   = '{8'h01, 8'h11, 8'h21, 8'h31};
    rr_b   = '{8'h00, 8'h01, 8'h02, 8'hF0};
    rr_sum = '{8'h01, 8'h12, 8'h23, 8'h21};
    rr_c   = '{1'b0, 1'b0, 1'b0, 1'b1};

    set_all_valid(1'b0);
    for (int i = 0; i < N; i++) begin
      req_a[i] = 8'h00;
      req_b[i] = 8'h00;
    end
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();

    // Reset / idle state
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy", busy, 0);
    check("reset served_cnt", served_cnt, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset rsp_sum", rsp_sum, 0);
    check("reset rsp_carry", rsp_carry, 0);
    check("reset rsp_status", rsp_status, 0);
    check("reset rsp_nib", rsp_nib, 0);
    check("reset req_ready", rdy_vec, 0);

    // Single-requester vector table
    rsp_ready = 1'b1;
    exp_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      req_valid[vecs[v].id] = 1'b1;
      req_a[vecs[v].id] = vecs[v].a;
      req_b[vecs[v].id] = vecs[v].b;
      #1;
      check("vec grant ready", rdy_vec, 32'(4'b0001 << vecs[v].id));
      tick();
      req_valid[vecs[v].id] = 1'b0;
      check("vec calc busy", busy, 1);
      check("vec calc rsp_valid", rsp_valid, 0);
      check("vec calc ready", rdy_vec, 0);
      tick();
      check("vec rsp_valid", rsp_valid, 1);
      check("vec rsp_id", rsp_id, vecs[v].id);
      check("vec rsp_sum", rsp_sum, vecs[v].sum);
      check("vec rsp_carry", rsp_carry, vecs[v].carry);
      check("vec rsp_status", rsp_status, vecs[v].status);
      check("vec nib.x", rsp_nib.x, vecs[v].sum[3:0]);
      check("vec nib.y", rsp_nib.y, vecs[v].sum[7:4]);
      $display("[TB] vec %0d id=%0d a=%02h b=%02h -> sum=%02h carry=%0d status=%0d",
               v, rsp_id, vecs[v].a, vecs[v].b, rsp_sum, rsp_carry, rsp_status);
      tick();
      exp_cnt++;
      check("vec served_cnt", served_cnt, exp_cnt);
      check("vec back to idle", busy, 0);
    end

    // Back-to-back round robin with all requesters valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      req_a[i] = rr_a[i];
      req_b[i] = rr_b[i];
    end
    set_all_valid(1'b1);
    #1;
    check("rr first grant", rdy_vec, 4'b0001);
    tick();
    check("rr calc ready", rdy_vec, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr rsp_valid", rsp_valid, 1);
      check("rr rsp_id", rsp_id, k % N);
      check("rr rsp_sum", rsp_sum, rr_sum[k % N]);
      check("rr rsp_carry", rsp_carry, rr_c[k % N]);
      check("rr next grant", rdy_vec, 32'(4'b0001 << ((k + 1) % N)));
      $display("[TB] rr %0d id=%0d sum=%02h carry=%0d", k, rsp_id, rsp_sum, rsp_carry);
      tick();
      check("rr calc rsp_valid", rsp_valid, 0);
      check("rr calc ready", rdy_vec, 0);
      check("rr served_cnt", served_cnt, k + 1);
      tick();
    end

    // Response stall: requester 1's result waits for rsp_ready
    rsp_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      #1;
      check("stall ready", rdy_vec, 0);
      check("stall rsp_valid", rsp_valid, 1);
      check("stall rsp_id", rsp_id, 1);
      check("stall rsp_sum", rsp_sum, 8'h12);
      check("stall served_cnt", served_cnt, 5);
      tick();
    end
    rsp_ready = 1'b1;
    set_all_valid(1'b0);
    #1;
    check("stall release ready", rdy_vec, 0);
    $display("[TB] stall release id=%0d sum=%02h", rsp_id, rsp_sum);
    tick();
    check("stall served_cnt after", served_cnt, 6);
    check("stall idle rsp_valid", rsp_valid, 0);
    check("stall idle busy", busy, 0);

    // Reset during CALC discards the operation and rewinds rr_ptr
    set_all_valid(1'b1);
    #1;
    check("midrst grant ptr2", rdy_vec, 4'b0100);
    tick();
    check("midrst calc busy", busy, 1);
    rst_n = 1'b0;
    #2;
    set_all_valid(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst no rsp", rsp_valid, 0);
    end
    check("midrst served_cnt", served_cnt, 0);
    check("midrst busy", busy, 0);
    set_all_valid(1'b1);
    #1;
    check("midrst grant ptr0", rdy_vec, 4'b0001);
    tick();
    set_all_valid(1'b0);
    tick();
    check("midrst rsp_id", rsp_id, 0);
    check("midrst rsp_sum", rsp_sum, 8'h01);
    $display("[TB] post-reset id=%0d sum=%02h", rsp_id, rsp_sum);
    tick();
    check("midrst served after", served_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
